// File: rtl/sensor_stream_scheduler_pkg.sv
// sensor_stream_scheduler_pkg: shared state encoding, header tag and per-stream payload sizes.
package sensor_stream_scheduler_pkg;
    localparam int        NUM_STREAMS = 8;
    localparam logic [3:0] HDR_TAG    = 4'hA;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_CSUM,
        S_DONE
    } state_t;
    // Stream 0 carries a 32-bit sample, all others 16-bit.
    function automatic logic [2:0] payload_bytes(input logic [2:0] id);
        return (id == 3'd0) ? 3'd4 : 3'd2;
    endfunction
    function automatic logic [7:0] hdr_byte(input logic [2:0] id);
        return {HDR_TAG, 1'b0, id};
    endfunction
endpackage

// File: rtl/sensor_stream_scheduler_rr_arbiter8.sv
// rr_arbiter8: combinational round-robin pick of the first request at or after i_rr_ptr.
module rr_arbiter8
    import sensor_stream_scheduler_pkg::*;
(
    input  logic [7:0] i_req,
    input  logic [2:0] i_rr_ptr,
    output logic       o_grant_valid,
    output logic [2:0] o_grant_id
);
    logic [2:0] w_idx;
    // Scan from the farthest offset back to rr_ptr so the nearest request wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = i_rr_ptr;
        w_idx         = i_rr_ptr;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            w_idx = i_rr_ptr + 3'(k);
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_id    = w_idx;
            end
        end
    end
endmodule

// File: rtl/sensor_stream_scheduler.sv
// sensor_stream_scheduler: round-robin framing of 8 sensor streams onto one byte-wide TX path.
// Define SENSOR_SCHED_CHECKSUM_EN to append an XOR checksum byte after the payload.
module sensor_stream_scheduler
    import sensor_stream_scheduler_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] sensor_stream0,
    input  logic [15:0] sensor_stream1,
    input  logic [15:0] sensor_stream2,
    input  logic [15:0] sensor_stream3,
    input  logic [15:0] sensor_stream4,
    input  logic [15:0] sensor_stream5,
    input  logic [15:0] sensor_stream6,
    input  logic [15:0] sensor_stream7,
    input  logic [7:0]  sensor_stream_ready,
    input  logic [7:0]  stream_enable,
    output logic [7:0]  sensor_stream_ack,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    state_t      r_state, w_state_nx;
    logic [2:0]  r_rr_ptr, w_rr_nx;
    logic [2:0]  r_id, w_id_nx;
    logic [31:0] r_shift, w_shift_nx;
    logic [2:0]  r_left, w_left_nx;
    logic [7:0]  r_out_data, w_data_nx;
    logic        r_out_valid, w_valid_nx;
    logic [7:0]  r_ack, w_ack_nx;
    logic        w_gnt_valid;
    logic [2:0]  w_gnt_id;
    logic [31:0] w_sample;
    logic        w_hs;
`ifdef SENSOR_SCHED_CHECKSUM_EN
    logic [7:0]  r_csum, w_csum_nx;
`endif

    rr_arbiter8 u_arb (
        .i_req         (sensor_stream_ready & stream_enable),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_gnt_valid),
        .o_grant_id    (w_gnt_id)
    );

    assign w_hs              = r_out_valid && out_ready;
    assign sensor_stream_ack = r_ack;
    assign out_data          = r_out_data;
    assign out_valid         = r_out_valid;
    assign busy              = (r_state != S_IDLE);

    // Select the granted sample; 16-bit streams are left-justified so payload always leaves from [31:24].
    always_comb begin
        w_sample = 32'h0;
        case (w_gnt_id)
            3'd0: w_sample = sensor_stream0;
            3'd1: w_sample = {sensor_stream1, 16'h0};
            3'd2: w_sample = {sensor_stream2, 16'h0};
            3'd3: w_sample = {sensor_stream3, 16'h0};
            3'd4: w_sample = {sensor_stream4, 16'h0};
            3'd5: w_sample = {sensor_stream5, 16'h0};
            3'd6: w_sample = {sensor_stream6, 16'h0};
            default: w_sample = {sensor_stream7, 16'h0};
        endcase
    end

    // Next-state and registered-output logic; output byte is loaded on state entry or on each handshake.
    always_comb begin
        w_state_nx = r_state;
        w_rr_nx    = r_rr_ptr;
        w_id_nx    = r_id;
        w_shift_nx = r_shift;
        w_left_nx  = r_left;
        w_data_nx  = r_out_data;
        w_valid_nx = r_out_valid;
        w_ack_nx   = 8'h00;
`ifdef SENSOR_SCHED_CHECKSUM_EN
        w_csum_nx  = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_gnt_valid) begin
                    w_ack_nx   = 8'h01 << w_gnt_id;
                    w_id_nx    = w_gnt_id;
                    w_shift_nx = w_sample;
                    w_state_nx = S_HDR;
                end
            end
            S_HDR: begin
                if (!r_out_valid) begin
                    w_valid_nx = 1'b1;
                    w_data_nx  = hdr_byte(r_id);
                end else if (out_ready) begin
                    w_data_nx  = r_shift[31:24];
                    w_left_nx  = payload_bytes(r_id);
                    w_state_nx = S_PAY;
`ifdef SENSOR_SCHED_CHECKSUM_EN
                    w_csum_nx  = r_out_data;
`endif
                end
            end
            S_PAY: begin
                if (w_hs) begin
                    w_shift_nx = {r_shift[23:0], 8'h00};
                    w_left_nx  = r_left - 3'd1;
`ifdef SENSOR_SCHED_CHECKSUM_EN
                    w_csum_nx  = r_csum ^ r_out_data;
`endif
                    if (r_left == 3'd1) begin
`ifdef SENSOR_SCHED_CHECKSUM_EN
                        w_data_nx  = r_csum ^ r_out_data;
                        w_state_nx = S_CSUM;
`else
                        w_valid_nx = 1'b0;
                        w_state_nx = S_DONE;
`endif
                    end else begin
                        w_data_nx = r_shift[23:16];
                    end
                end
            end
`ifdef SENSOR_SCHED_CHECKSUM_EN
            S_CSUM: begin
                if (w_hs) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_rr_nx    = r_id + 3'd1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_valid_nx = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 3'd0;
            r_id        <= 3'd0;
            r_shift     <= 32'h0;
            r_left      <= 3'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_ack       <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_rr_ptr    <= w_rr_nx;
            r_id        <= w_id_nx;
            r_shift     <= w_shift_nx;
            r_left      <= w_left_nx;
            r_out_data  <= w_data_nx;
            r_out_valid <= w_valid_nx;
            r_ack       <= w_ack_nx;
        end
    end

`ifdef SENSOR_SCHED_CHECKSUM_EN
    // Running XOR of header and payload bytes already sent.
    always_ff @(posedge clock) begin
        if (!reset) r_csum <= 8'h00;
        else        r_csum <= w_csum_nx;
    end
`endif
endmodule
